pcie_us_cfg_mgmt_arb: RTL and testbench

//  Shares the single UltraScale PCIe hard-IP cfg_mgmt port between PORTS requesters with round-robin arbitration.

---
 rtl/pcie_us_cfg_mgmt_arb.sv | 170 +++++++++++++++++
 tb/tb_pcie_us_cfg_mgmt_arb.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_us_cfg_mgmt_arb.sv
// Round-robin arbiter sharing the UltraScale PCIe cfg_mgmt port between PORTS requesters.
// Optional build macro CFG_MGMT_ARB_HDR_PROTECT_EN rejects non-port-0 writes to type-0 header DWORDs 0..15.
module pcie_us_cfg_mgmt_arb #(
    parameter int unsigned PORTS      = 2,
    parameter int unsigned ADDR_WIDTH = 19,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORTS-1:0]            s_req_valid,
    output logic [PORTS-1:0]            s_req_ready,
    input  logic [PORTS-1:0]            s_req_write,
    input  logic [PORTS*ADDR_WIDTH-1:0] s_req_addr,
    input  logic [PORTS*32-1:0]         s_req_write_data,
    input  logic [PORTS*4-1:0]          s_req_byte_enable,
    output logic [PORTS-1:0]            m_rsp_valid,
    output logic [31:0]                 m_rsp_data,
    output logic                        m_rsp_error,
    output logic [ADDR_WIDTH-1:0]       cfg_mgmt_addr,
    output logic                        cfg_mgmt_write,
    output logic [31:0]                 cfg_mgmt_write_data,
    output logic [3:0]                  cfg_mgmt_byte_enable,
    output logic                        cfg_mgmt_read,
    input  logic [31:0]                 cfg_mgmt_read_data,
    input  logic                        cfg_mgmt_read_write_done,
    output logic                        busy
);

    localparam int unsigned PW = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int unsigned CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_grant;
    logic            r_write;
    logic [CW-1:0]   r_cnt;

    logic                  w_found;
    logic [PW-1:0]         w_grant;
    int unsigned           w_best;
    logic [PORTS-1:0]      w_grant_oh;
    logic [PORTS-1:0]      w_owner_oh;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [31:0]           w_sel_data;
    logic [3:0]            w_sel_be;
    logic                  w_sel_write;
    logic                  w_reject;

    // Pick the valid port with the smallest rotational distance past the last winner.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_best  = PORTS;
        for (int unsigned j = 0; j < PORTS; j++) begin
            if (s_req_valid[j] &&
                (((j + 2 * PORTS - 1 - 32'(r_ptr)) % PORTS) < w_best)) begin
                w_best  = (j + 2 * PORTS - 1 - 32'(r_ptr)) % PORTS;
                w_grant = PW'(j);
                w_found = 1'b1;
            end
        end
    end

    // Payload of the port about to be granted.
    always_comb begin
        w_sel_addr  = '0;
        w_sel_data  = '0;
        w_sel_be    = '0;
        w_sel_write = 1'b0;
        for (int unsigned j = 0; j < PORTS; j++) begin
            if (w_grant == PW'(j)) begin
                w_sel_addr  = s_req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_data  = s_req_write_data[j*32 +: 32];
                w_sel_be    = s_req_byte_enable[j*4 +: 4];
                w_sel_write = s_req_write[j];
            end
        end
    end

`ifdef CFG_MGMT_ARB_HDR_PROTECT_EN
    assign w_reject = w_sel_write && (w_grant != '0) && (w_sel_addr[9:0] < 10'h010);
`else
    assign w_reject = 1'b0;
`endif

    assign w_grant_oh  = PORTS'(1) << w_grant;
    assign w_owner_oh  = PORTS'(1) << r_grant;
    assign s_req_ready = (r_state == ST_IDLE && w_found && !rst) ? w_grant_oh : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state              <= ST_IDLE;
            r_ptr                <= PW'(PORTS - 1);
            r_grant              <= '0;
            r_write              <= 1'b0;
            r_cnt                <= '0;
            m_rsp_valid          <= '0;
            m_rsp_data           <= '0;
            m_rsp_error          <= 1'b0;
            cfg_mgmt_addr        <= '0;
            cfg_mgmt_write       <= 1'b0;
            cfg_mgmt_write_data  <= '0;
            cfg_mgmt_byte_enable <= '0;
            cfg_mgmt_read        <= 1'b0;
            busy                 <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_ptr   <= w_grant;
                        r_grant <= w_grant;
                        r_write <= w_sel_write;
                        r_cnt   <= '0;
                        if (w_reject) begin
                            r_state     <= ST_RESP;
                            m_rsp_valid <= w_grant_oh;
                            m_rsp_data  <= '0;
                            m_rsp_error <= 1'b1;
                        end else begin
                            r_state              <= ST_ACCESS;
                            busy                 <= 1'b1;
                            cfg_mgmt_addr        <= w_sel_addr;
                            cfg_mgmt_write_data  <= w_sel_data;
                            cfg_mgmt_byte_enable <= w_sel_be;
                            cfg_mgmt_write       <= w_sel_write;
                            cfg_mgmt_read        <= !w_sel_write;
                        end
                    end
                end
                ST_ACCESS: begin
                    // done takes priority over a coincident timeout
                    if (cfg_mgmt_read_write_done) begin
                        r_state        <= ST_RESP;
                        busy           <= 1'b0;
                        cfg_mgmt_write <= 1'b0;
                        cfg_mgmt_read  <= 1'b0;
                        m_rsp_valid    <= w_owner_oh;
                        m_rsp_data     <= r_write ? 32'h0 : cfg_mgmt_read_data;
                        m_rsp_error    <= 1'b0;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_state        <= ST_RESP;
                        busy           <= 1'b0;
                        cfg_mgmt_write <= 1'b0;
                        cfg_mgmt_read  <= 1'b0;
                        m_rsp_valid    <= w_owner_oh;
                        m_rsp_data     <= '0;
                        m_rsp_error    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_RESP: begin
                    r_state              <= ST_IDLE;
                    m_rsp_valid          <= '0;
                    cfg_mgmt_addr        <= '0;
                    cfg_mgmt_write_data  <= '0;
                    cfg_mgmt_byte_enable <= '0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pcie_us_cfg_mgmt_arb.sv
// Bench for pcie_us_cfg_mgmt_arb: transaction-level reference model compared every cycle, plus directed literal checks.
module tb_pcie_us_cfg_mgmt_arb;

    localparam int PORTS   = 2;
    localparam int AW      = 19;
    localparam int TIMEOUT = 1024;
`ifdef CFG_MGMT_ARB_HDR_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic                  clk;
    logic                  rst;
    logic [PORTS-1:0]      s_req_valid;
    logic [PORTS-1:0]      s_req_ready;
    logic [PORTS-1:0]      s_req_write;
    logic [PORTS*AW-1:0]   s_req_addr;
    logic [PORTS*32-1:0]   s_req_write_data;
    logic [PORTS*4-1:0]    s_req_byte_enable;
    logic [PORTS-1:0]      m_rsp_valid;
    logic [31:0]           m_rsp_data;
    logic                  m_rsp_error;
    logic [AW-1:0]         cfg_mgmt_addr;
    logic                  cfg_mgmt_write;
    logic [31:0]           cfg_mgmt_write_data;
    logic [3:0]            cfg_mgmt_byte_enable;
    logic                  cfg_mgmt_read;
    logic [31:0]           cfg_mgmt_read_data;
    logic                  cfg_mgmt_read_write_done;
    logic                  busy;

    pcie_us_cfg_mgmt_arb #(.PORTS(PORTS), .ADDR_WIDTH(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_write(s_req_write),
        .s_req_addr(s_req_addr), .s_req_write_data(s_req_write_data), .s_req_byte_enable(s_req_byte_enable),
        .m_rsp_valid(m_rsp_valid), .m_rsp_data(m_rsp_data), .m_rsp_error(m_rsp_error),
        .cfg_mgmt_addr(cfg_mgmt_addr), .cfg_mgmt_write(cfg_mgmt_write),
        .cfg_mgmt_write_data(cfg_mgmt_write_data), .cfg_mgmt_byte_enable(cfg_mgmt_byte_enable),
        .cfg_mgmt_read(cfg_mgmt_read), .cfg_mgmt_read_data(cfg_mgmt_read_data),
        .cfg_mgmt_read_write_done(cfg_mgmt_read_write_done), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Simple core responder: done on the core_lat-th consecutive strobe cycle (0 = never).
    int core_lat  = 0;
    int core_cnt  = 0;
    bit spur_done = 1'b0;
    always @(posedge clk) begin
        #1;
        if (cfg_mgmt_read || cfg_mgmt_write) core_cnt++;
        else core_cnt = 0;
        cfg_mgmt_read_write_done = spur_done || (core_lat != 0 && core_cnt == core_lat);
    end

    // Reference model: one access at a time, tracked as the current transaction.
    function automatic int pick(input logic [PORTS-1:0] v, input int ptr);
        for (int k = 1; k <= PORTS; k++) begin
            if (v[(ptr + k) % PORTS]) return (ptr + k) % PORTS;
        end
        return -1;
    endfunction

    int               ph = 0;            // 0 waiting for request, 1 core busy, 2 answering
    int               e_ptr = PORTS - 1;
    int               e_g = 0;
    int               m_cnt = 0;
    bit               m_write = 1'b0;
    logic [PORTS-1:0] e_rv = '0;
    logic [31:0]      e_rd = '0;
    logic             e_re = 1'b0;
    logic [AW-1:0]    e_addr = '0;
    logic [31:0]      e_wd = '0;
    logic [3:0]       e_be = '0;
    logic             e_wr = 1'b0;
    logic             e_rdst = 1'b0;
    logic             e_busy = 1'b0;

    always @(posedge clk) begin
        int g;
        logic [AW-1:0] a;
        if (rst) begin
            ph = 0; e_ptr = PORTS - 1; e_rv = '0; e_rd = '0; e_re = 1'b0;
            e_addr = '0; e_wd = '0; e_be = '0; e_wr = 1'b0; e_rdst = 1'b0; e_busy = 1'b0;
        end else if (ph == 0) begin
            g = pick(s_req_valid, e_ptr);
            if (g >= 0) begin
                e_ptr = g; e_g = g; m_cnt = 0;
                m_write = s_req_write[g];
                a = s_req_addr[g*AW +: AW];
                if (PROT && m_write && g != 0 && a[9:0] < 10'h010) begin
                    ph = 2; e_rv = PORTS'(1) << g; e_rd = '0; e_re = 1'b1;
                end else begin
                    ph = 1; e_busy = 1'b1; e_addr = a;
                    e_wd = s_req_write_data[g*32 +: 32];
                    e_be = s_req_byte_enable[g*4 +: 4];
                    e_wr = m_write; e_rdst = !m_write;
                end
            end
        end else if (ph == 1) begin
            m_cnt++;
            if (cfg_mgmt_read_write_done || m_cnt == TIMEOUT) begin
                ph = 2; e_busy = 1'b0; e_wr = 1'b0; e_rdst = 1'b0;
                e_rv = PORTS'(1) << e_g;
                e_re = !cfg_mgmt_read_write_done;
                e_rd = (cfg_mgmt_read_write_done && !m_write) ? cfg_mgmt_read_data : 32'h0;
            end
        end else begin
            ph = 0; e_rv = '0; e_addr = '0; e_wd = '0; e_be = '0;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [PORTS-1:0] e_rdy;
        int g;
        g = pick(s_req_valid, e_ptr);
        e_rdy = (ph == 0 && !rst && g >= 0) ? PORTS'(1) << g : '0;
        n_vec++;
        if (s_req_ready !== e_rdy || m_rsp_valid !== e_rv || m_rsp_data !== e_rd || m_rsp_error !== e_re ||
            cfg_mgmt_addr !== e_addr || cfg_mgmt_write_data !== e_wd || cfg_mgmt_byte_enable !== e_be ||
            cfg_mgmt_write !== e_wr || cfg_mgmt_read !== e_rdst || busy !== e_busy) begin
            n_miss++;
            $display("FAIL cycle_compare cyc %0d: rdy %b/%b rspv %b/%b data %h/%h err %b/%b addr %h/%h wd %h/%h be %h/%h wr %b/%b rd %b/%b busy %b/%b",
                     cyc, s_req_ready, e_rdy, m_rsp_valid, e_rv, m_rsp_data, e_rd, m_rsp_error, e_re,
                     cfg_mgmt_addr, e_addr, cfg_mgmt_write_data, e_wd, cfg_mgmt_byte_enable, e_be,
                     cfg_mgmt_write, e_wr, cfg_mgmt_read, e_rdst, busy, e_busy);
        end
    end

    // Event recorder for the directed checks.
    int               cur_len = 0, last_len = 0, strobe_total = 0;
    int               acc_port_q[$], acc_cyc_q[$], rsp_cyc_q[$];
    logic [PORTS-1:0] rsp_v_q[$];
    logic [31:0]      rsp_d_q[$];
    logic             rsp_e_q[$];
    always @(negedge clk) begin
        if (cfg_mgmt_read || cfg_mgmt_write) begin
            cur_len++; strobe_total++;
        end else if (cur_len > 0) begin
            last_len = cur_len; cur_len = 0;
        end
        if (|s_req_ready) begin
            acc_port_q.push_back(s_req_ready[1] ? 1 : 0);
            acc_cyc_q.push_back(cyc);
        end
        if (|m_rsp_valid) begin
            rsp_v_q.push_back(m_rsp_valid); rsp_d_q.push_back(m_rsp_data);
            rsp_e_q.push_back(m_rsp_error); rsp_cyc_q.push_back(cyc);
        end
    end

    task automatic ticks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        ticks(3);
        rst = 1'b0;
    endtask

    task automatic issue(input int p, input bit wr, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
        int n;
        @(posedge clk); #1;
        s_req_write[p] = wr;
        s_req_addr[p*AW +: AW] = a;
        s_req_write_data[p*32 +: 32] = d;
        s_req_byte_enable[p*4 +: 4] = be;
        s_req_valid[p] = 1'b1;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!s_req_ready[p] && n < 40);
        if (!s_req_ready[p]) check("accept_timeout", 64'(n), 64'(0));
        @(posedge clk); #1 s_req_valid[p] = 1'b0;
    endtask

    task automatic wait_rsp(input int n, input int budget);
        int k;
        k = 0;
        while (rsp_v_q.size() < n && k < budget) begin
            @(posedge clk); k++;
        end
        #1;
        if (rsp_v_q.size() < n) check("response_timeout", 64'(rsp_v_q.size()), 64'(n));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int b, ba, k;
        rst = 1'b1; s_req_valid = '0; s_req_write = '0; s_req_addr = '0;
        s_req_write_data = '0; s_req_byte_enable = '0; cfg_mgmt_read_data = '0;
        cfg_mgmt_read_write_done = 1'b0;
        ticks(3);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_read", 64'(cfg_mgmt_read), 64'(0));
        check("reset_rspv", 64'(m_rsp_valid), 64'(0));
        check("reset_data", 64'(m_rsp_data), 64'(0));
        check("reset_addr", 64'(cfg_mgmt_addr), 64'(0));

        // single read, done on 3rd strobe cycle
        core_lat = 3; cfg_mgmt_read_data = 32'h00100406;
        issue(0, 1'b0, 19'h004, 32'h0, 4'hF);
        wait_rsp(1, 50);
        check("t1_strobe_len", 64'(last_len), 64'(3));
        check("t1_rspv", 64'(rsp_v_q[0]), 64'(2'b01));
        check("t1_data", 64'(rsp_d_q[0]), 64'h00100406);
        check("t1_err", 64'(rsp_e_q[0]), 64'(0));
        check("t1_latency", 64'(rsp_cyc_q[0] - acc_cyc_q[0]), 64'(4));

        // spurious done while idle
        b = rsp_v_q.size();
        @(negedge clk); spur_done = 1'b1;
        @(negedge clk); spur_done = 1'b0;
        ticks(4);
        check("spur_no_rsp", 64'(rsp_v_q.size()), 64'(b));
        check("spur_busy", 64'(busy), 64'(0));

        // both ports continuously requesting after reset
        do_reset();
        core_lat = 2;
        b = rsp_v_q.size(); ba = acc_port_q.size();
        s_req_addr = {19'h011, 19'h010}; s_req_write = 2'b00;
        @(posedge clk); #1 s_req_valid = 2'b11;
        k = 0;
        while (acc_port_q.size() < ba + 4 && k < 100) begin
            @(posedge clk); k++;
        end
        #1 s_req_valid = 2'b00;
        wait_rsp(b + 4, 50);
        if (acc_port_q.size() >= ba + 4 && rsp_cyc_q.size() >= b + 4) begin
            for (int i = 0; i < 4; i++) check("t2_grant_order", 64'(acc_port_q[ba+i]), 64'(i % 2));
            for (int i = 0; i < 3; i++) check("t2_back_to_back", 64'(acc_cyc_q[ba+i+1] - rsp_cyc_q[b+i]), 64'(1));
        end

        // write that never completes: full timeout
        core_lat = 0;
        b = rsp_v_q.size();
        issue(1, 1'b1, 19'h044, 32'hDEADBEEF, 4'hF);
        wait_rsp(b + 1, 1100);
        if (rsp_v_q.size() > b) begin
            check("t3_strobe_len", 64'(last_len), 64'(1024));
            check("t3_rspv", 64'(rsp_v_q[b]), 64'(2'b10));
            check("t3_err", 64'(rsp_e_q[b]), 64'(1));
            check("t3_data", 64'(rsp_d_q[b]), 64'(0));
        end

        // reset during an in-flight access from port 0
        core_lat = 0;
        b = rsp_v_q.size();
        issue(0, 1'b0, 19'h008, 32'h0, 4'hF);
        ticks(3);
        rst = 1'b1;
        ticks(1);
        rst = 1'b0;
        @(negedge clk);
        check("t4_strobe_dropped", 64'({cfg_mgmt_read, cfg_mgmt_write}), 64'(0));
        check("t4_no_rspv", 64'(m_rsp_valid), 64'(0));
        ticks(4);
        check("t4_no_response", 64'(rsp_v_q.size()), 64'(b));
        core_lat = 2; cfg_mgmt_read_data = 32'hA5A50001;
        ba = acc_port_q.size();
        s_req_addr = {19'h020, 19'h00C}; s_req_write = 2'b00;
        @(posedge clk); #1 s_req_valid = 2'b11;
        k = 0;
        while (acc_port_q.size() == ba && k < 20) begin
            @(posedge clk); k++;
        end
        #1 s_req_valid = 2'b00;
        wait_rsp(b + 1, 30);
        ticks(5);
        if (acc_port_q.size() > ba && rsp_v_q.size() > b) begin
            check("t4_ptr_reset_grant", 64'(acc_port_q[ba]), 64'(0));
            check("t4_rspv", 64'(rsp_v_q[b]), 64'(2'b01));
            check("t4_data", 64'(rsp_d_q[b]), 64'hA5A50001);
            check("t4_dropped_req", 64'(acc_port_q.size() - ba), 64'(1));
        end

`ifdef CFG_MGMT_ARB_HDR_PROTECT_EN
        // header write from port 1 rejected, same write from port 0 issued
        b = rsp_v_q.size(); ba = acc_cyc_q.size(); k = strobe_total;
        issue(1, 1'b1, 19'h001, 32'h12345678, 4'hF);
        wait_rsp(b + 1, 20);
        if (rsp_v_q.size() > b) begin
            check("prot_no_strobe", 64'(strobe_total - k), 64'(0));
            check("prot_rspv", 64'(rsp_v_q[b]), 64'(2'b10));
            check("prot_err", 64'(rsp_e_q[b]), 64'(1));
            check("prot_latency", 64'(rsp_cyc_q[b] - acc_cyc_q[ba]), 64'(1));
        end
        core_lat = 2;
        issue(0, 1'b1, 19'h001, 32'h12345678, 4'hF);
        wait_rsp(b + 2, 20);
        if (rsp_v_q.size() > b + 1) begin
            check("prot_p0_strobe", 64'(last_len), 64'(2));
            check("prot_p0_rspv", 64'(rsp_v_q[b+1]), 64'(2'b01));
            check("prot_p0_err", 64'(rsp_e_q[b+1]), 64'(0));
        end
`endif

        ticks(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
